// File: rtl/core_run_pkg.sv
// rtl/core_run_pkg.sv - shared run-control state and debug command encodings
package core_run_pkg;

  typedef enum logic [2:0] {
    ST_RUN        = 3'd0,
    ST_DRAIN      = 3'd1,
    ST_HALT       = 3'd2,
    ST_STEP_FETCH = 3'd3,
    ST_STEP_WAIT  = 3'd4
  } run_state_t;

  typedef enum logic [2:0] {
    CMD_NOP    = 3'd0,
    CMD_HALT   = 3'd1,
    CMD_RESUME = 3'd2,
    CMD_STEP   = 3'd3,
    CMD_CLRCNT = 3'd4
  } cmd_code_t;

endpackage

// File: rtl/core_run_ctrl.sv
// rtl/core_run_ctrl.sv - debug run control: halt/drain, single step with timeout, retire counter
module core_run_ctrl
  import core_run_pkg::*;
#(
  parameter int unsigned CNT_WIDTH    = 32,
  parameter int unsigned STEP_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 dbg_on_rst,
  input  logic                 cmd_valid,
  input  logic [2:0]           cmd,
  output logic                 cmd_ready,
  input  logic                 insn_retire,
  input  logic                 pipe_empty,
  output logic                 fetch_en,
  output logic                 halted,
  output logic                 step_done,
  output logic                 step_err,
  output logic                 cmd_err,
  output logic [CNT_WIDTH-1:0] retire_cnt
);

  localparam int unsigned TW = $clog2(STEP_TIMEOUT + 1);

  run_state_t    state, next_state;
  logic [TW-1:0] wait_cnt;
  logic          cmd_acc, cmd_legal, clr_cnt, retire_done, timeout;
  logic          fetch_en_d, halted_d, step_done_d, step_err_d, cmd_err_d;

  assign cmd_ready   = (state == ST_RUN) || (state == ST_HALT);
  assign cmd_acc     = cmd_valid && cmd_ready;
  assign clr_cnt     = cmd_acc && (cmd == CMD_CLRCNT);
  assign retire_done = insn_retire && pipe_empty;
  assign timeout     = (state == ST_STEP_WAIT) && (wait_cnt == TW'(STEP_TIMEOUT - 1));

  // STEP is only meaningful from HALT; undefined codes are never legal
  always_comb begin
    cmd_legal = 1'b0;
    case (cmd)
      CMD_NOP, CMD_HALT, CMD_RESUME, CMD_CLRCNT: cmd_legal = 1'b1;
      CMD_STEP:                                  cmd_legal = (state == ST_HALT);
      default:                                   cmd_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= dbg_on_rst ? ST_HALT : ST_RUN;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_RUN:        if (cmd_acc && cmd == CMD_HALT) next_state = ST_DRAIN;
      ST_DRAIN:      if (pipe_empty) next_state = ST_HALT;
      ST_HALT: begin
        if (cmd_acc && cmd == CMD_RESUME)    next_state = ST_RUN;
        else if (cmd_acc && cmd == CMD_STEP) next_state = ST_STEP_FETCH;
      end
      ST_STEP_FETCH: next_state = ST_STEP_WAIT;
      ST_STEP_WAIT:  if (retire_done || timeout) next_state = ST_HALT;
      default:       next_state = ST_HALT;
    endcase
  end

  // outputs are computed from next_state so the registered copies line up with state
  always_comb begin
    fetch_en_d  = (next_state == ST_RUN) || (next_state == ST_STEP_FETCH);
    halted_d    = (next_state == ST_HALT);
    step_done_d = (state == ST_STEP_WAIT) && (next_state == ST_HALT);
    cmd_err_d   = cmd_acc && !cmd_legal;
    step_err_d  = step_err;
    if (cmd_acc && cmd != CMD_NOP) step_err_d = 1'b0;
    if (timeout && !retire_done)   step_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_en  <= !dbg_on_rst;
      halted    <= dbg_on_rst;
      step_done <= 1'b0;
      step_err  <= 1'b0;
      cmd_err   <= 1'b0;
    end else begin
      fetch_en  <= fetch_en_d;
      halted    <= halted_d;
      step_done <= step_done_d;
      step_err  <= step_err_d;
      cmd_err   <= cmd_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || state != ST_STEP_WAIT) wait_cnt <= '0;
    else                              wait_cnt <= wait_cnt + TW'(1);
  end

  // a clear wins over a coincident retire
  always_ff @(posedge clk) begin
    if (rst || clr_cnt)   retire_cnt <= '0;
    else if (insn_retire) retire_cnt <= retire_cnt + CNT_WIDTH'(1);
  end

endmodule

// File: tb/tb_core_run_ctrl.sv
// tb/tb_core_run_ctrl.sv - scoreboard bench for core_run_ctrl
module tb_core_run_ctrl;

  logic        clk = 1'b0;
  logic        rst, dbg_on_rst, cmd_valid, insn_retire, pipe_empty;
  logic [2:0]  cmd;
  logic        cmd_ready, fetch_en, halted, step_done, step_err, cmd_err;
  logic [31:0] retire_cnt;
  logic        w_cmd_ready, w_fetch_en, w_halted, w_step_done, w_step_err, w_cmd_err;
  logic [3:0]  w_retire_cnt;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_cnt = 0;
  logic [31:0] cnt_q[$];
  logic [31:0] exp_cnt;

  always #5 clk = ~clk;

  core_run_ctrl dut (
    .clk(clk), .rst(rst), .dbg_on_rst(dbg_on_rst), .cmd_valid(cmd_valid), .cmd(cmd),
    .cmd_ready(cmd_ready), .insn_retire(insn_retire), .pipe_empty(pipe_empty),
    .fetch_en(fetch_en), .halted(halted), .step_done(step_done), .step_err(step_err),
    .cmd_err(cmd_err), .retire_cnt(retire_cnt)
  );

  core_run_ctrl #(.CNT_WIDTH(4)) dut_w (
    .clk(clk), .rst(rst), .dbg_on_rst(dbg_on_rst), .cmd_valid(cmd_valid), .cmd(cmd),
    .cmd_ready(w_cmd_ready), .insn_retire(insn_retire), .pipe_empty(pipe_empty),
    .fetch_en(w_fetch_en), .halted(w_halted), .step_done(w_step_done), .step_err(w_step_err),
    .cmd_err(w_cmd_err), .retire_cnt(w_retire_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cmd_valid   = 1'b0;
    cmd         = 3'd0;
    insn_retire = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    pipe_empty = 1'b1;
    rst = 1'b1; dbg_on_rst = 1'b1;
    tick(); tick();
    checks++; if (step_done !== 1'b0 || cmd_err !== 1'b0 || step_err !== 1'b0) begin errors++; $display("FAIL rst_pulses got %b%b%b exp 000", step_done, cmd_err, step_err); end
    checks++; if (retire_cnt !== 32'd0) begin errors++; $display("FAIL rst_cnt got %h exp 0", retire_cnt); end
    rst = 1'b0;
    tick();
    checks++; if (halted !== 1'b1 || fetch_en !== 1'b0) begin errors++; $display("FAIL rst_dbg_halt got halted=%b fetch_en=%b exp 1 0", halted, fetch_en); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_dbg_ready got %b exp 1", cmd_ready); end
    rst = 1'b1; dbg_on_rst = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    checks++; if (halted !== 1'b0 || fetch_en !== 1'b1) begin errors++; $display("FAIL rst_run got halted=%b fetch_en=%b exp 0 1", halted, fetch_en); end
    model_cnt = 0;
  endtask

  task automatic test_clrcnt();
    cmd_valid = 1'b1; cmd = 3'd4;
    model_cnt = 0; cnt_q.push_back(model_cnt);
    tick(); idle();
    exp_cnt = cnt_q.pop_front();
    checks++; if (retire_cnt !== exp_cnt) begin errors++; $display("FAIL clr_alone got %h exp %h", retire_cnt, exp_cnt); end
    for (int i = 0; i < 7; i++) begin
      insn_retire = 1'b1;
      model_cnt = model_cnt + 1; cnt_q.push_back(model_cnt);
      tick();
      exp_cnt = cnt_q.pop_front();
      checks++; if (retire_cnt !== exp_cnt) begin errors++; $display("FAIL cnt_inc got %h exp %h", retire_cnt, exp_cnt); end
    end
    cmd_valid = 1'b1; cmd = 3'd4; insn_retire = 1'b1;
    model_cnt = 0; cnt_q.push_back(model_cnt);
    tick(); idle();
    exp_cnt = cnt_q.pop_front();
    checks++; if (retire_cnt !== exp_cnt) begin errors++; $display("FAIL clr_vs_retire got %h exp %h", retire_cnt, exp_cnt); end
    checks++; if (fetch_en !== 1'b1 || cmd_err !== 1'b0) begin errors++; $display("FAIL clr_state got fetch_en=%b cmd_err=%b exp 1 0", fetch_en, cmd_err); end
    for (int i = 0; i < 16; i++) begin
      insn_retire = 1'b1;
      model_cnt = model_cnt + 1; cnt_q.push_back(model_cnt);
      tick();
      exp_cnt = cnt_q.pop_front();
      checks++; if (retire_cnt !== exp_cnt || w_retire_cnt !== exp_cnt[3:0]) begin errors++; $display("FAIL cnt_wrap got %h/%h exp %h/%h", retire_cnt, w_retire_cnt, exp_cnt, exp_cnt[3:0]); end
    end
    idle();
    checks++; if (w_retire_cnt !== 4'd0) begin errors++; $display("FAIL wrap_zero got %h exp 0", w_retire_cnt); end
  endtask

  task automatic test_step_in_run();
    cmd_valid = 1'b1; cmd = 3'd3;
    tick(); idle();
    checks++; if (cmd_err !== 1'b1 || fetch_en !== 1'b1 || halted !== 1'b0) begin errors++; $display("FAIL step_in_run got cmd_err=%b fetch_en=%b halted=%b exp 1 1 0", cmd_err, fetch_en, halted); end
    tick();
    checks++; if (cmd_err !== 1'b0) begin errors++; $display("FAIL cmd_err_pulse got %b exp 0", cmd_err); end
    cmd_valid = 1'b1; cmd = 3'd7;
    tick(); idle();
    checks++; if (cmd_err !== 1'b1) begin errors++; $display("FAIL undef_cmd got %b exp 1", cmd_err); end
    cmd_valid = 1'b1; cmd = 3'd2;
    tick(); idle();
    checks++; if (cmd_err !== 1'b0 || fetch_en !== 1'b1) begin errors++; $display("FAIL resume_in_run got cmd_err=%b fetch_en=%b exp 0 1", cmd_err, fetch_en); end
  endtask

  task automatic test_halt_drain();
    pipe_empty = 1'b0;
    cmd_valid = 1'b1; cmd = 3'd1;
    tick(); idle();
    checks++; if (fetch_en !== 1'b0 || cmd_ready !== 1'b0) begin errors++; $display("FAIL halt_next got fetch_en=%b cmd_ready=%b exp 0 0", fetch_en, cmd_ready); end
    for (int i = 0; i < 4; i++) begin
      insn_retire = (i == 1);
      if (i == 1) begin model_cnt = model_cnt + 1; cnt_q.push_back(model_cnt); end
      tick();
      checks++; if (halted !== 1'b0 || cmd_ready !== 1'b0 || fetch_en !== 1'b0) begin errors++; $display("FAIL drain_hold got halted=%b cmd_ready=%b fetch_en=%b exp 0 0 0", halted, cmd_ready, fetch_en); end
      if (i == 1) begin
        exp_cnt = cnt_q.pop_front();
        checks++; if (retire_cnt !== exp_cnt) begin errors++; $display("FAIL drain_retire got %h exp %h", retire_cnt, exp_cnt); end
      end
    end
    insn_retire = 1'b0;
    pipe_empty = 1'b1;
    tick();
    checks++; if (halted !== 1'b1 || fetch_en !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL drain_done got halted=%b fetch_en=%b cmd_ready=%b exp 1 0 1", halted, fetch_en, cmd_ready); end
  endtask

  task automatic test_step();
    int fetch_cycles = 0;
    int done_pulses = 0;
    cmd_valid = 1'b1; cmd = 3'd1;
    tick(); idle();
    checks++; if (cmd_err !== 1'b0 || halted !== 1'b1) begin errors++; $display("FAIL halt_in_halt got cmd_err=%b halted=%b exp 0 1", cmd_err, halted); end
    cmd_valid = 1'b1; cmd = 3'd3;
    tick(); idle();
    for (int i = 0; i < 10; i++) begin
      fetch_cycles += int'(fetch_en);
      done_pulses  += int'(step_done);
      insn_retire = (i == 3);
      pipe_empty  = (i >= 3);
      if (i == 3) begin model_cnt = model_cnt + 1; cnt_q.push_back(model_cnt); end
      tick();
      if (i == 3) begin
        exp_cnt = cnt_q.pop_front();
        checks++; if (retire_cnt !== exp_cnt) begin errors++; $display("FAIL step_retire got %h exp %h", retire_cnt, exp_cnt); end
      end
    end
    idle();
    checks++; if (fetch_cycles !== 1) begin errors++; $display("FAIL step_fetch_cycles got %0d exp 1", fetch_cycles); end
    checks++; if (done_pulses !== 1) begin errors++; $display("FAIL step_done_pulses got %0d exp 1", done_pulses); end
    checks++; if (halted !== 1'b1 || step_err !== 1'b0) begin errors++; $display("FAIL step_end got halted=%b step_err=%b exp 1 0", halted, step_err); end
  endtask

  task automatic test_step_timeout();
    pipe_empty = 1'b0;
    cmd_valid = 1'b1; cmd = 3'd3;
    tick(); idle();
    tick();
    for (int i = 0; i < 15; i++) begin
      tick();
      checks++; if (step_done !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL to_early cycle %0d got step_done=%b halted=%b exp 0 0", i, step_done, halted); end
    end
    tick();
    checks++; if (step_done !== 1'b1 || step_err !== 1'b1 || halted !== 1'b1) begin errors++; $display("FAIL to_fire got step_done=%b step_err=%b halted=%b exp 1 1 1", step_done, step_err, halted); end
    tick();
    checks++; if (step_done !== 1'b0 || step_err !== 1'b1) begin errors++; $display("FAIL to_sticky got step_done=%b step_err=%b exp 0 1", step_done, step_err); end
    pipe_empty = 1'b1;
    cmd_valid = 1'b1; cmd = 3'd2;
    tick(); idle();
    checks++; if (step_err !== 1'b0 || fetch_en !== 1'b1 || halted !== 1'b0) begin errors++; $display("FAIL to_resume got step_err=%b fetch_en=%b halted=%b exp 0 1 0", step_err, fetch_en, halted); end
  endtask

  task automatic test_rst_in_step();
    cmd_valid = 1'b1; cmd = 3'd1;
    tick(); idle();
    tick();
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL rs_halt got %b exp 1", halted); end
    cmd_valid = 1'b1; cmd = 3'd3;
    tick(); idle();
    pipe_empty = 1'b0;
    tick(); tick();
    rst = 1'b1; dbg_on_rst = 1'b0;
    insn_retire = 1'b1; pipe_empty = 1'b1;
    model_cnt = 0; cnt_q.push_back(model_cnt);
    tick();
    exp_cnt = cnt_q.pop_front();
    checks++; if (step_done !== 1'b0 || fetch_en !== 1'b1 || halted !== 1'b0) begin errors++; $display("FAIL rs_abort got step_done=%b fetch_en=%b halted=%b exp 0 1 0", step_done, fetch_en, halted); end
    checks++; if (retire_cnt !== exp_cnt) begin errors++; $display("FAIL rs_cnt got %h exp %h", retire_cnt, exp_cnt); end
    rst = 1'b0; idle();
    tick();
    checks++; if (step_done !== 1'b0 || fetch_en !== 1'b1 || cmd_ready !== 1'b1) begin errors++; $display("FAIL rs_after got step_done=%b fetch_en=%b cmd_ready=%b exp 0 1 1", step_done, fetch_en, cmd_ready); end
  endtask

  initial begin
    test_reset();
    test_clrcnt();
    test_step_in_run();
    test_halt_drain();
    test_step();
    test_step_timeout();
    test_rst_in_step();
    checks++; if (cnt_q.size() !== 0) begin errors++; $display("FAIL sb_leftover got %0d exp 0", cnt_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

endmodule
